// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and read-port indices.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    WAIT = 2'd3
  } arb_state_t;

  localparam int PORT_CPU  = 0;
  localparam int PORT_SND  = 1;
  localparam int PORT_TILE = 2;
  localparam int PORT_SPR  = 3;

  // Pointer width that stays legal for a single-port build.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of pend at or after ptr, wrapping NPORTS-1 -> 0.
module rr_picker #(
  parameter int NPORTS = 4,
  parameter int PW     = 2
) (
  input  logic [NPORTS-1:0] pend,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     grant,
  output logic              any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest pending port wins.
  always_comb begin
    grant = '0;
    any   = |pend;
    idx   = 0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (pend[idx]) grant = PW'(idx);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller between the ROM downloader (absolute priority) and NPORTS
// round-robin read ports. Optional per-port read cache: define SDRAM_ARB_CACHE_EN.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int AW     = 23,
  parameter int DW     = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 rom_download,
  input  logic                 dl_wr,
  input  logic [AW-1:0]        dl_addr,
  input  logic [DW-1:0]        dl_data,
  output logic                 dl_ovf,
  input  logic [NPORTS-1:0]    port_req,
  input  logic [NPORTS*AW-1:0] port_addr,
  output logic [NPORTS-1:0]    port_ack,
  output logic [DW-1:0]        port_dout,
  output logic                 sd_req,
  output logic                 sd_we,
  output logic [AW-1:0]        sd_addr,
  output logic [DW-1:0]        sd_din,
  input  logic                 sd_rdy,
  input  logic                 sd_valid,
  input  logic [DW-1:0]        sd_dout,
  output logic [1:0]           state_dbg
);

  localparam int PW = ptr_width(NPORTS);

  // Controller handshake: a command is presented by holding sd_req with sd_we/sd_addr/sd_din
  // frozen until the cycle sd_rdy is high; read data comes back later on a sd_valid cycle.
  arb_state_t        state, state_nx;
  logic [NPORTS-1:0] pend, miss_req, req_vec;
  logic [AW-1:0]     pend_addr [NPORTS];
  logic [PW-1:0]     rr_ptr, grant, pick;
  logic              pick_any;
  logic [AW-1:0]     pick_addr;
  logic              dl_full;
  logic [AW-1:0]     dl_buf_addr;
  logic [DW-1:0]     dl_buf_data;
  logic              start_wr, start_rd, wr_accept, rd_done;
  logic              hit_any;
  logic [PW-1:0]     hit_idx;
  logic [DW-1:0]     hit_data;

  assign req_vec   = pend | miss_req;
  assign pick_addr = miss_req[pick] ? port_addr[pick*AW +: AW] : pend_addr[pick];
  assign start_wr  = (state == IDLE) && dl_full;
  assign start_rd  = (state == IDLE) && !dl_full && !rom_download && pick_any;
  assign wr_accept = (state == WR) && sd_rdy;
  assign rd_done   = (state == WAIT) && sd_valid;
  assign state_dbg = state;

  rr_picker #(.NPORTS(NPORTS), .PW(PW)) u_picker (
    .pend  (req_vec),
    .ptr   (rr_ptr),
    .grant (pick),
    .any   (pick_any)
  );

`ifdef SDRAM_ARB_CACHE_EN
  logic [NPORTS-1:0] tag_vld, hit;
  logic [AW-1:0]     tag   [NPORTS];
  logic [DW-1:0]     cdata [NPORTS];

  // One hit served per cycle (lowest port); a hit colliding with a read return or another
  // hit falls back to a normal SDRAM read so port_dout is never contended.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    hit_idx = '0;
    if (!rd_done) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (port_req[i] && tag_vld[i] && tag[i] == port_addr[i*AW +: AW]) begin
          hit_any = 1'b1;
          hit_idx = PW'(i);
        end
      end
    end
    if (hit_any) hit[hit_idx] = 1'b1;
  end

  assign miss_req = port_req & ~hit;
  assign hit_data = cdata[hit_idx];

  always_ff @(posedge clk_sys) begin
    if (reset || dl_wr || wr_accept) begin
      tag_vld <= '0;
    end else if (rd_done) begin
      tag_vld[grant] <= 1'b1;
      tag[grant]     <= sd_addr;
      cdata[grant]   <= sd_dout;
    end
  end
`else
  assign hit_any  = 1'b0;
  assign hit_idx  = '0;
  assign hit_data = '0;
  assign miss_req = port_req;
`endif

  always_comb begin
    state_nx = state;
    sd_req   = 1'b0;
    sd_we    = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr)      state_nx = WR;
        else if (start_rd) state_nx = RD;
      end
      WR: begin
        sd_req = 1'b1;
        sd_we  = 1'b1;
        if (sd_rdy) state_nx = IDLE;
      end
      RD: begin
        sd_req = 1'b1;
        if (sd_rdy) state_nx = WAIT;
      end
      WAIT: begin
        if (sd_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      pend        <= '0;
      dl_full     <= 1'b0;
      dl_ovf      <= 1'b0;
      dl_buf_addr <= '0;
      dl_buf_data <= '0;
      port_ack    <= '0;
      port_dout   <= '0;
      sd_addr     <= '0;
      sd_din      <= '0;
      for (int i = 0; i < NPORTS; i++) pend_addr[i] <= '0;
    end else begin
      state    <= state_nx;
      port_ack <= '0;

      // A new strobe wins over completion so it is never lost.
      for (int i = 0; i < NPORTS; i++) begin
        if (miss_req[i]) begin
          pend[i]      <= 1'b1;
          pend_addr[i] <= port_addr[i*AW +: AW];
        end else if (rd_done && grant == PW'(i)) begin
          pend[i] <= 1'b0;
        end
      end

      if (start_wr) begin
        sd_addr <= dl_buf_addr;
        sd_din  <= dl_buf_data;
      end else if (start_rd) begin
        sd_addr <= pick_addr;
        grant   <= pick;
      end

      if (rd_done) begin
        port_dout       <= sd_dout;
        port_ack[grant] <= 1'b1;
        rr_ptr          <= (grant == PW'(NPORTS - 1)) ? '0 : grant + 1'b1;
      end else if (hit_any) begin
        port_dout         <= hit_data;
        port_ack[hit_idx] <= 1'b1;
      end

      // Single-entry download buffer; a write landing in the accept cycle refills it.
      if (dl_wr && dl_full && !wr_accept) begin
        dl_ovf <= 1'b1;
      end else if (dl_wr) begin
        dl_full     <= 1'b1;
        dl_buf_addr <= dl_addr;
        dl_buf_data <= dl_data;
      end else if (wr_accept) begin
        dl_full <= 1'b0;
      end
    end
  end

endmodule
